// File: rtl/sd_spi_bridge_pkg.sv
// Shared definitions for the SD card SPI command bridge: opcodes,
// FSM state encoding and the length-byte helper.
package sd_spi_bridge_pkg;

    localparam logic [7:0] OP_CS_LOW  = 8'h01;
    localparam logic [7:0] OP_CS_HIGH = 8'h02;
    localparam logic [7:0] OP_XFER    = 8'h03;
    localparam logic [7:0] OP_DIV     = 8'h04;
    localparam logic [7:0] OP_READ    = 8'h05;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        XLEN  = 4'd1,
        XDATA = 4'd2,
        XSEND = 4'd3,
        XRESP = 4'd4,
        RLEN  = 4'd5,
        RSEND = 4'd6,
        RRESP = 4'd7,
        DIV   = 4'd8
    } state_t;

    // A length byte of zero encodes 256 transfers.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/sd_spi_bridge_byte_fifo.sv
// Synchronous byte FIFO with occupancy count. A write on a full FIFO is
// accepted only when a read happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == FULL_LEVEL);
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sd_spi_bridge.sv
// UART-to-SPI command bridge for the SD loopback: decodes framed opcodes
// from uartRx, drives chip-select, clock divider and SPI byte transfers,
// and streams MISO responses back to uartTx through a byte FIFO.
module sd_spi_bridge
    import sd_spi_bridge_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [3:0] DEFAULT_DIV = 4'd15,
    parameter logic [7:0] READ_FILL   = 8'hFF
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iRxData,
    input  logic       iRxValid,
    output logic       oSpiSend,
    output logic [7:0] oSpiData,
    input  logic       iSpiTaken,
    input  logic [7:0] iSpiData,
    input  logic       iSpiAvail,
    output logic [3:0] oSpiClkDiv,
    output logic       oCs,
    output logic [7:0] oTxData,
    output logic       oTxStart,
    input  logic       iTxReady,
    output logic       oOverflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LEVEL = CW'(FIFO_DEPTH - 1);

    state_t        state;
    logic [8:0]    remaining;
    logic          push;
    logic          pop;
    logic          rx_busy;
    logic          low_room;
    logic          last_byte;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;

    // Response push, TX pop and the conditions that gate the FSM.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        rx_busy   = 1'b0;
        low_room  = (fifo_count >= STALL_LEVEL);
        last_byte = (remaining == 9'd1);
        if ((state == XRESP || state == RRESP) && iSpiAvail) begin
            push = 1'b1;
        end
        if (state == XSEND || state == XRESP || state == RSEND || state == RRESP) begin
            rx_busy = 1'b1;
        end
        if (!fifo_empty && iTxReady && !oTxStart) begin
            pop = 1'b1;
        end
    end

    byte_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_resp_fifo (
        .clk     (iClk),
        .rst     (iRst),
        .wr_en   (push),
        .wr_data (iSpiData),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Command decoder and SPI transfer sequencer; CS and divider move only from IDLE/DIV.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= IDLE;
            remaining  <= 9'd0;
            oCs        <= 1'b1;
            oSpiSend   <= 1'b0;
            oSpiData   <= 8'd0;
            oSpiClkDiv <= DEFAULT_DIV;
        end else begin
            case (state)
                IDLE: begin
                    if (iRxValid) begin
                        case (iRxData)
                            OP_CS_LOW:  oCs   <= 1'b0;
                            OP_CS_HIGH: oCs   <= 1'b1;
                            OP_XFER:    state <= XLEN;
                            OP_DIV:     state <= DIV;
                            OP_READ:    state <= RLEN;
                            default:    state <= IDLE;
                        endcase
                    end
                end
                XLEN: begin
                    if (iRxValid) begin
                        remaining <= len_to_count(iRxData);
                        state     <= XDATA;
                    end
                end
                XDATA: begin
                    if (iRxValid) begin
                        oSpiData <= iRxData;
                        oSpiSend <= 1'b1;
                        state    <= XSEND;
                    end
                end
                XSEND: begin
                    if (iSpiTaken) begin
                        oSpiSend <= 1'b0;
                        state    <= XRESP;
                    end
                end
                XRESP: begin
                    if (iSpiAvail) begin
                        remaining <= remaining - 9'd1;
                        state     <= last_byte ? IDLE : XDATA;
                    end
                end
                RLEN: begin
                    if (iRxValid) begin
                        remaining <= len_to_count(iRxData);
                        state     <= RSEND;
                    end
                end
                RSEND: begin
                    // Hold off new reads until the FIFO can absorb the reply.
                    if (!oSpiSend) begin
                        if (!low_room) begin
                            oSpiData <= READ_FILL;
                            oSpiSend <= 1'b1;
                        end
                    end else if (iSpiTaken) begin
                        oSpiSend <= 1'b0;
                        state    <= RRESP;
                    end
                end
                RRESP: begin
                    if (iSpiAvail) begin
                        remaining <= remaining - 9'd1;
                        state     <= last_byte ? IDLE : RSEND;
                    end
                end
                DIV: begin
                    if (iRxValid) begin
                        oSpiClkDiv <= iRxData[3:0];
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error: UART byte arriving mid-transfer, or a push the FIFO cannot take.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oOverflow <= 1'b0;
        end else if ((iRxValid && rx_busy) || (push && fifo_full && !pop)) begin
            oOverflow <= 1'b1;
        end
    end

    // TX streaming: one start pulse at most every other cycle, data registered with it.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oTxStart <= 1'b0;
            oTxData  <= 8'd0;
        end else begin
            oTxStart <= pop;
            if (pop) begin
                oTxData <= fifo_head;
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_bridge.sv
// Directed bench for sd_spi_bridge: a command table for CS/DIV handling,
// plus hand-written XFER, READ-stall, overflow and reset-abort sequences.
module tb_sd_spi_bridge;

    logic       iClk;
    logic       iRst;
    logic [7:0] iRxData;
    logic       iRxValid;
    logic       oSpiSend;
    logic [7:0] oSpiData;
    logic       iSpiTaken;
    logic [7:0] iSpiData;
    logic       iSpiAvail;
    logic [3:0] oSpiClkDiv;
    logic       oCs;
    logic [7:0] oTxData;
    logic       oTxStart;
    logic       iTxReady;
    logic       oOverflow;

    // SPI slave model signals and manually driven overrides
    logic       m_taken;
    logic       m_avail;
    logic [7:0] m_data;
    logic       t_avail;
    logic [7:0] t_data;
    logic       spi_en;
    logic       echo;
    logic [7:0] miso_val;
    int         avail_cnt;
    int         hold_viol;
    logic [7:0] mosi_log [$];

    // TX monitor
    logic       prev_start;
    int         spacing_err;
    logic [7:0] tx_log [$];

    int n_tests;
    int n_fail;

    assign iSpiTaken = m_taken;
    assign iSpiAvail = m_avail | t_avail;
    assign iSpiData  = t_avail ? t_data : m_data;

    sd_spi_bridge #(
        .FIFO_DEPTH  (16),
        .DEFAULT_DIV (4'd15),
        .READ_FILL   (8'hFF)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iRxData    (iRxData),
        .iRxValid   (iRxValid),
        .oSpiSend   (oSpiSend),
        .oSpiData   (oSpiData),
        .iSpiTaken  (iSpiTaken),
        .iSpiData   (iSpiData),
        .iSpiAvail  (iSpiAvail),
        .oSpiClkDiv (oSpiClkDiv),
        .oCs        (oCs),
        .oTxData    (oTxData),
        .oTxStart   (oTxStart),
        .iTxReady   (iTxReady),
        .oOverflow  (oOverflow)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         n;
        logic       cs;
        logic [3:0] div;
    } cmd_vec_t;

    cmd_vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge iClk);
        iRxData  = b;
        iRxValid = 1'b1;
        @(negedge iClk);
        iRxValid = 1'b0;
    endtask

    task automatic wait_avail(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (avail_cnt < target && n < budget) begin
            @(negedge iClk);
            n++;
        end
        if (avail_cnt < target) begin
            check({name, "_timeout"}, 32'(avail_cnt), 32'(target));
        end
    endtask

    // SPI slave: hold-checks the request, accepts it, then returns a MISO byte.
    initial begin
        logic [7:0] cap;
        m_taken   = 1'b0;
        m_avail   = 1'b0;
        m_data    = 8'd0;
        avail_cnt = 0;
        hold_viol = 0;
        forever begin
            @(negedge iClk);
            if (spi_en && oSpiSend && !iRst) begin
                cap = oSpiData;
                repeat (2) begin
                    @(negedge iClk);
                    if (!oSpiSend || oSpiData !== cap) hold_viol++;
                end
                m_taken = 1'b1;
                mosi_log.push_back(cap);
                @(negedge iClk);
                m_taken = 1'b0;
                repeat (2) @(negedge iClk);
                m_data  = echo ? ~cap : miso_val;
                m_avail = 1'b1;
                avail_cnt++;
                @(negedge iClk);
                m_avail = 1'b0;
            end
        end
    end

    // TX monitor: logs every started byte and flags back-to-back starts.
    initial begin
        prev_start  = 1'b0;
        spacing_err = 0;
        forever begin
            @(negedge iClk);
            if (oTxStart) begin
                tx_log.push_back(oTxData);
                if (prev_start) spacing_err++;
            end
            prev_start = oTxStart;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_tx;
        int base_mosi;
        int base_avail;
        int n;
        int bad;

        n_tests  = 0;
        n_fail   = 0;
        iRst     = 1'b1;
        iRxValid = 1'b0;
        iRxData  = 8'd0;
        iTxReady = 1'b1;
        t_avail  = 1'b0;
        t_data   = 8'd0;
        spi_en   = 1'b1;
        echo     = 1'b1;
        miso_val = 8'd0;

        vecs[0] = '{b0: 8'h01, b1: 8'h00, n: 1, cs: 1'b0, div: 4'hF};
        vecs[1] = '{b0: 8'h02, b1: 8'h00, n: 1, cs: 1'b1, div: 4'hF};
        vecs[2] = '{b0: 8'h04, b1: 8'h03, n: 2, cs: 1'b1, div: 4'h3};
        vecs[3] = '{b0: 8'h04, b1: 8'hF7, n: 2, cs: 1'b1, div: 4'h7};
        vecs[4] = '{b0: 8'h01, b1: 8'h00, n: 1, cs: 1'b0, div: 4'h7};
        vecs[5] = '{b0: 8'h06, b1: 8'h00, n: 1, cs: 1'b0, div: 4'h7};
        vecs[6] = '{b0: 8'h04, b1: 8'h00, n: 2, cs: 1'b0, div: 4'h0};
        vecs[7] = '{b0: 8'hFF, b1: 8'h00, n: 1, cs: 1'b0, div: 4'h0};
        vecs[8] = '{b0: 8'h02, b1: 8'h00, n: 1, cs: 1'b1, div: 4'h0};

        // Reset values
        repeat (3) @(negedge iClk);
        check("rst_cs", 32'(oCs), 32'd1);
        check("rst_send", 32'(oSpiSend), 32'd0);
        check("rst_spidata", 32'(oSpiData), 32'd0);
        check("rst_div", 32'(oSpiClkDiv), 32'hF);
        check("rst_txstart", 32'(oTxStart), 32'd0);
        check("rst_txdata", 32'(oTxData), 32'd0);
        check("rst_ovf", 32'(oOverflow), 32'd0);
        iRst = 1'b0;
        @(negedge iClk);

        // Command table: CS and DIV handling, invalid opcodes ignored
        for (int i = 0; i < 9; i++) begin
            base_tx   = tx_log.size();
            base_mosi = mosi_log.size();
            send_byte(vecs[i].b0);
            if (vecs[i].n == 2) send_byte(vecs[i].b1);
            check($sformatf("vec%0d_cs", i), 32'(oCs), 32'(vecs[i].cs));
            check($sformatf("vec%0d_div", i), 32'(oSpiClkDiv), 32'(vecs[i].div));
            repeat (2) @(negedge iClk);
            check($sformatf("vec%0d_nosend", i), 32'(oSpiSend), 32'd0);
            check($sformatf("vec%0d_notx", i), 32'(tx_log.size() - base_tx), 32'd0);
            check($sformatf("vec%0d_nospi", i), 32'(mosi_log.size() - base_mosi), 32'd0);
        end

        // XFER of two bytes with the slave echoing ~MOSI
        echo       = 1'b1;
        base_tx    = tx_log.size();
        base_mosi  = mosi_log.size();
        base_avail = avail_cnt;
        send_byte(8'h03);
        send_byte(8'h02);
        send_byte(8'hA5);
        check("xfer_send_lat", 32'(oSpiSend), 32'd1);
        check("xfer_data0", 32'(oSpiData), 32'hA5);
        wait_avail("xfer_b0", base_avail + 1, 100);
        send_byte(8'h3C);
        wait_avail("xfer_b1", base_avail + 2, 100);
        repeat (10) @(negedge iClk);
        check("xfer_mosi_n", 32'(mosi_log.size() - base_mosi), 32'd2);
        check("xfer_mosi0", 32'(mosi_log[base_mosi]), 32'hA5);
        check("xfer_mosi1", 32'(mosi_log[base_mosi + 1]), 32'h3C);
        check("xfer_tx_n", 32'(tx_log.size() - base_tx), 32'd2);
        check("xfer_tx0", 32'(tx_log[base_tx]), 32'h5A);
        check("xfer_tx1", 32'(tx_log[base_tx + 1]), 32'hC3);
        check("xfer_hold", 32'(hold_viol), 32'd0);
        check("xfer_ovf", 32'(oOverflow), 32'd0);
        send_byte(8'h01);
        check("xfer_idle_cs", 32'(oCs), 32'd0);
        send_byte(8'h02);
        check("xfer_idle_cs2", 32'(oCs), 32'd1);

        // READ of 256 bytes with TX blocked: must stall at 15 queued
        iTxReady   = 1'b0;
        echo       = 1'b0;
        miso_val   = 8'h55;
        base_tx    = tx_log.size();
        base_mosi  = mosi_log.size();
        base_avail = avail_cnt;
        send_byte(8'h05);
        send_byte(8'h00);
        repeat (300) @(negedge iClk);
        check("read_stall_cnt", 32'(avail_cnt - base_avail), 32'd15);
        check("read_stall_send", 32'(oSpiSend), 32'd0);
        check("read_stall_notx", 32'(tx_log.size() - base_tx), 32'd0);
        check("read_stall_ovf", 32'(oOverflow), 32'd0);
        iTxReady = 1'b1;
        n = 0;
        while (tx_log.size() < base_tx + 256 && n < 8000) begin
            @(negedge iClk);
            n++;
        end
        repeat (20) @(negedge iClk);
        check("read_tx_n", 32'(tx_log.size() - base_tx), 32'd256);
        bad = 0;
        for (int k = base_tx; k < tx_log.size(); k++) if (tx_log[k] !== 8'h55) bad++;
        check("read_tx_vals", 32'(bad), 32'd0);
        check("read_mosi_n", 32'(mosi_log.size() - base_mosi), 32'd256);
        bad = 0;
        for (int k = base_mosi; k < mosi_log.size(); k++) if (mosi_log[k] !== 8'hFF) bad++;
        check("read_mosi_fill", 32'(bad), 32'd0);
        check("read_spacing", 32'(spacing_err), 32'd0);
        check("read_hold", 32'(hold_viol), 32'd0);
        check("read_ovf", 32'(oOverflow), 32'd0);
        send_byte(8'h01);
        check("read_idle_cs", 32'(oCs), 32'd0);

        // Extra UART byte during XSEND: dropped, sticky overflow, transfer completes
        echo       = 1'b1;
        base_tx    = tx_log.size();
        base_mosi  = mosi_log.size();
        base_avail = avail_cnt;
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h77);
        send_byte(8'h99);
        check("ovf_set", 32'(oOverflow), 32'd1);
        wait_avail("ovf_xfer", base_avail + 1, 100);
        repeat (10) @(negedge iClk);
        check("ovf_sticky", 32'(oOverflow), 32'd1);
        check("ovf_mosi_n", 32'(mosi_log.size() - base_mosi), 32'd1);
        check("ovf_mosi", 32'(mosi_log[base_mosi]), 32'h77);
        check("ovf_tx", 32'(tx_log[base_tx]), 32'h88);
        send_byte(8'h04);
        send_byte(8'h02);
        check("ovf_idle_div", 32'(oSpiClkDiv), 32'h2);

        // Reset while a transfer is pending, then a late MISO strobe
        spi_en  = 1'b0;
        base_tx = tx_log.size();
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'hAB);
        check("abort_send_pre", 32'(oSpiSend), 32'd1);
        check("abort_cs_pre", 32'(oCs), 32'd0);
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst    = 1'b0;
        t_avail = 1'b1;
        t_data  = 8'h42;
        @(negedge iClk);
        t_avail = 1'b0;
        repeat (10) @(negedge iClk);
        check("abort_send", 32'(oSpiSend), 32'd0);
        check("abort_cs", 32'(oCs), 32'd1);
        check("abort_div", 32'(oSpiClkDiv), 32'hF);
        check("abort_ovf", 32'(oOverflow), 32'd0);
        check("abort_notx", 32'(tx_log.size() - base_tx), 32'd0);
        send_byte(8'h01);
        check("abort_idle_cs", 32'(oCs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
